intr_src_capture: RTL and testbench

Front end of the interrupt path: it sits directly upstream of the interrupt controller and drives that controller's `intr_active_i` vector. Raw peripheral interrupt lines enter asynchronously. The block synchronizes them and applies a per-source edge/level mode and mask. Edge events are latched as pending until the controller reports the interrupt serviced or software clears them. Mode, mask and pending state are programmed over the same simple APB-style register port the controller uses.

---
 rtl/intr_pkg.sv | 21 ++
 rtl/intr_sync.sv | 25 ++
 rtl/intr_src_capture.sv | 121 ++++++++++++
 tb/tb_intr_src_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Constants shared by the interrupt capture front end and the interrupt controller.
package intr_pkg;

  localparam int unsigned INTR_MAX_SRC     = 16;
  localparam int unsigned INTR_ID_W        = 4;
  localparam int unsigned INTR_SYNC_STAGES = 2;

  localparam logic [7:0] INTR_ADDR_MODE_LO = 8'h00;
  localparam logic [7:0] INTR_ADDR_MODE_HI = 8'h01;
  localparam logic [7:0] INTR_ADDR_MASK_LO = 8'h02;
  localparam logic [7:0] INTR_ADDR_MASK_HI = 8'h03;
  localparam logic [7:0] INTR_ADDR_PEND_LO = 8'h04;
  localparam logic [7:0] INTR_ADDR_PEND_HI = 8'h05;

  typedef logic [INTR_MAX_SRC-1:0] intr_vec_t;

  function automatic logic [7:0] intr_byte(input intr_vec_t v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/intr_sync.sv
// Flop-chain synchronizer for a vector of asynchronous inputs.
module intr_sync #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] chain_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[Depth-1];

endmodule

// File: rtl/intr_src_capture.sv
// Interrupt source capture: synchronizes raw lines, applies edge/level mode and mask,
// and holds edge events pending until serviced or cleared over the register port.
module intr_src_capture
  import intr_pkg::*;
#(
  parameter int unsigned NUM_INTR    = 16,
  parameter int unsigned SYNC_STAGES = INTR_SYNC_STAGES
) (
  input  logic                 pclk_i,
  input  logic                 prst_ni,
  input  logic [7:0]           paddr_i,
  input  logic [7:0]           pwdata_i,
  input  logic                 pwrite_i,
  input  logic                 penable_i,
  output logic [7:0]           prdata_o,
  output logic                 pready_o,
  output logic                 perror_o,
  input  logic [NUM_INTR-1:0]  periph_intr_i,
  input  logic                 intr_serviced_i,
  input  logic [INTR_ID_W-1:0] intr_serviced_id_i,
  output logic [NUM_INTR-1:0]  intr_active_o
);

  logic [NUM_INTR-1:0] sync_s, hist_q;
  logic [NUM_INTR-1:0] pend_q, pend_d, mode_q, mode_d, mask_q, mask_d;
  logic [NUM_INTR-1:0] rise, clr, mode_chg;
  intr_vec_t           rd_mode, rd_mask, rd_pend, mode_w, mask_w, pclr_w, svc_w;
  logic                acc_start, addr_ok, wr_en;
  logic                pready_q, pready_d, perror_q, perror_d;
  logic [7:0]          prdata_q, prdata_d;

  intr_sync #(
    .Width (NUM_INTR),
    .Depth (SYNC_STAGES)
  ) u_sync (
    .clk_i  (pclk_i),
    .rst_ni (prst_ni),
    .d_i    (periph_intr_i),
    .q_o    (sync_s)
  );

  assign acc_start = penable_i & ~pready_q;
  assign addr_ok   = paddr_i <= INTR_ADDR_PEND_HI;
  assign wr_en     = acc_start & pwrite_i & addr_ok;

  always_comb begin
    rd_mode = '0;
    rd_mask = '0;
    rd_pend = '0;
    rd_mode[NUM_INTR-1:0] = mode_q;
    rd_mask[NUM_INTR-1:0] = mask_q;
    rd_pend[NUM_INTR-1:0] = pend_q;
    mode_w = rd_mode;
    mask_w = rd_mask;
    pclr_w = '0;
    svc_w  = '0;
    if (wr_en) begin
      case (paddr_i)
        INTR_ADDR_MODE_LO: mode_w[7:0]  = pwdata_i;
        INTR_ADDR_MODE_HI: mode_w[15:8] = pwdata_i;
        INTR_ADDR_MASK_LO: mask_w[7:0]  = pwdata_i;
        INTR_ADDR_MASK_HI: mask_w[15:8] = pwdata_i;
        INTR_ADDR_PEND_LO: pclr_w[7:0]  = pwdata_i;
        INTR_ADDR_PEND_HI: pclr_w[15:8] = pwdata_i;
        default: ;
      endcase
    end
    // Ids at or above NUM_INTR land in the discarded upper bits.
    if (intr_serviced_i) svc_w[intr_serviced_id_i] = 1'b1;
    mode_d   = mode_w[NUM_INTR-1:0];
    mask_d   = mask_w[NUM_INTR-1:0];
    mode_chg = mode_d ^ mode_q;
    rise     = sync_s & ~hist_q;
    clr      = (pclr_w[NUM_INTR-1:0] | svc_w[NUM_INTR-1:0]) & mode_q;
    // A fresh edge outranks any clear in the same cycle.
    pend_d   = ((mode_q & (rise | (pend_q & ~clr))) | (~mode_q & sync_s)) & ~mode_chg;
  end

  always_comb begin
    pready_d = acc_start;
    perror_d = acc_start & ~addr_ok;
    prdata_d = prdata_q;
    if (acc_start && !pwrite_i) begin
      case (paddr_i)
        INTR_ADDR_MODE_LO: prdata_d = intr_byte(rd_mode, 1'b0);
        INTR_ADDR_MODE_HI: prdata_d = intr_byte(rd_mode, 1'b1);
        INTR_ADDR_MASK_LO: prdata_d = intr_byte(rd_mask, 1'b0);
        INTR_ADDR_MASK_HI: prdata_d = intr_byte(rd_mask, 1'b1);
        INTR_ADDR_PEND_LO: prdata_d = intr_byte(rd_pend, 1'b0);
        INTR_ADDR_PEND_HI: prdata_d = intr_byte(rd_pend, 1'b1);
        default:           prdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      hist_q   <= '0;
      pend_q   <= '0;
      mode_q   <= '0;
      mask_q   <= '0;
      pready_q <= 1'b0;
      perror_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      hist_q   <= sync_s;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      pready_q <= pready_d;
      perror_q <= perror_d;
      prdata_q <= prdata_d;
    end
  end

  assign pready_o      = pready_q;
  assign perror_o      = perror_q;
  assign prdata_o      = prdata_q;
  assign intr_active_o = pend_q & mask_q;

endmodule

// File: tb/tb_intr_src_capture.sv
// Scoreboard bench for intr_src_capture: bus responses and intr_active_o are queued at
// stimulus time and popped by a negedge monitor.
module tb_intr_src_capture;
  import intr_pkg::*;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic [7:0]  paddr = '0, pwdata = '0, prdata;
  logic        pwrite = 1'b0, penable = 1'b0, pready, perror;
  logic [15:0] periph = '0, active;
  logic        svc = 1'b0;
  logic [3:0]  svc_id = '0;

  typedef struct packed {
    logic       err;
    logic       chk_d;
    logic [7:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [15:0] act_q[$];
  int          errors = 0;
  int          checks = 0;

  intr_src_capture #(
    .NUM_INTR    (16),
    .SYNC_STAGES (2)
  ) dut (
    .pclk_i             (pclk),
    .prst_ni            (prst_n),
    .paddr_i            (paddr),
    .pwdata_i           (pwdata),
    .pwrite_i           (pwrite),
    .penable_i          (penable),
    .prdata_o           (prdata),
    .pready_o           (pready),
    .perror_o           (perror),
    .periph_intr_i      (periph),
    .intr_serviced_i    (svc),
    .intr_serviced_id_i (svc_id),
    .intr_active_o      (active)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (pready) begin
      if (resp_q.size() == 0) begin
        check("unexpected_pready", 16'(pready), 16'h0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("perror", 16'(perror), 16'(r.err));
        if (r.chk_d) check("prdata", 16'(prdata), 16'(r.data));
      end
    end
    if (act_q.size() != 0) check("intr_active", active, act_q.pop_front());
  end

  task automatic step(input logic [15:0] exp_act);
    @(posedge pclk);
    #1;
    act_q.push_back(exp_act);
  endtask

  task automatic bus(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_d, input logic exp_e,
                     input logic chk_act = 1'b0, input logic [15:0] exp_act = '0);
    resp_t r;
    r.err   = exp_e;
    r.chk_d = ~wr;
    r.data  = exp_d;
    resp_q.push_back(r);
    penable = 1'b1;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge pclk);
    #1;
    penable = 1'b0;
    if (chk_act) act_q.push_back(exp_act);
    @(posedge pclk);
    #1;
    check("bus_resp_seen", 16'(resp_q.size()), 16'h0);
    resp_q.delete();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    bus(1'b0, a, 8'h00, exp, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_regs [6];

    // Reset defaults, including reset landing in the middle of an access
    #2;
    check("rst_active", active, 16'h0);
    repeat (3) @(posedge pclk);
    #1;
    prst_n = 1'b1;
    wr(INTR_ADDR_MASK_LO, 8'h5A);
    rd(INTR_ADDR_MASK_LO, 8'h5A);
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = INTR_ADDR_MODE_LO;
    pwdata  = 8'hFF;
    #3;
    prst_n = 1'b0;
    #1;
    check("rst_mid_pready", 16'(pready), 16'h0);
    check("rst_mid_perror", 16'(perror), 16'h0);
    check("rst_mid_prdata", 16'(prdata), 16'h0);
    check("rst_mid_active", active, 16'h0);
    penable = 1'b0;
    @(posedge pclk);
    #1;
    prst_n = 1'b1;
    for (int i = 0; i < 6; i++) rd(8'(i), 8'h00);

    // Edge capture, hold after line falls, service clears next cycle
    wr(INTR_ADDR_MODE_LO, 8'h01);
    wr(INTR_ADDR_MASK_LO, 8'h01);
    periph[0] = 1'b1;
    step(16'h0000);
    step(16'h0000);
    periph[0] = 1'b0;
    step(16'h0001);
    step(16'h0001);
    step(16'h0001);
    svc    = 1'b1;
    svc_id = 4'd0;
    step(16'h0000);
    svc    = 1'b0;
    rd(INTR_ADDR_PEND_LO, 8'h00);

    // Level tracking on source 15; servicing a level source has no effect
    wr(INTR_ADDR_MODE_LO, 8'h00);
    wr(INTR_ADDR_MASK_LO, 8'h00);
    wr(INTR_ADDR_MASK_HI, 8'h80);
    periph[15] = 1'b1;
    step(16'h0000);
    step(16'h0000);
    step(16'h8000);
    step(16'h8000);
    svc    = 1'b1;
    svc_id = 4'd15;
    step(16'h8000);
    svc        = 1'b0;
    periph[15] = 1'b0;
    step(16'h8000);
    step(16'h8000);
    step(16'h0000);

    // Edge detect on source 3 coincides with a W1C of the same bit
    wr(INTR_ADDR_MODE_LO, 8'h08);
    periph[3] = 1'b1;
    step(16'h0000);
    step(16'h0000);
    wr(INTR_ADDR_PEND_LO, 8'h08);
    rd(INTR_ADDR_PEND_LO, 8'h08);
    wr(INTR_ADDR_PEND_LO, 8'h08);
    rd(INTR_ADDR_PEND_LO, 8'h00);
    periph[3] = 1'b0;

    // Masked pending survives; unmasking raises the output next cycle
    wr(INTR_ADDR_MASK_HI, 8'h00);
    wr(INTR_ADDR_MODE_LO, 8'h20);
    periph[5] = 1'b1;
    for (int i = 0; i < 4; i++) step(16'h0000);
    rd(INTR_ADDR_PEND_LO, 8'h20);
    bus(1'b1, INTR_ADDR_MASK_LO, 8'h20, 8'h00, 1'b0, 1'b1, 16'h0020);
    step(16'h0020);

    // Illegal addresses: error response, read data zero, no register change
    bus(1'b0, 8'h07, 8'h00, 8'h00, 1'b1);
    bus(1'b1, 8'h06, 8'hFF, 8'h00, 1'b1);
    exp_regs = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00};
    for (int i = 0; i < 6; i++) rd(8'(i), exp_regs[i]);
    step(16'h0020);

    repeat (2) @(posedge pclk);
    #1;
    check("queues_drained", 16'(act_q.size() + resp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
